// File: rtl/dmem_wait_responder_if.sv
// Data-memory port bundle between the processor (master) and the
// wait-state memory responder (slave).
interface dmem_wait_responder_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output memread, memwrite, addr, writedata,
    input  readdata, ready, busy, err
  );

  modport slave (
    input  memread, memwrite, addr, writedata,
    output readdata, ready, busy, err
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// Word-addressed data memory that completes each read/write after
// WAIT_CYCLES wait states with a one-cycle ready pulse. It flags misaligned
// and out-of-range accesses through err. The request is latched on
// acceptance, so the initiator may change its inputs while the access is in
// flight. All outputs come straight from flops.
module dmem_wait_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  dmem_wait_responder_if.slave        bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  // Storage is deliberately not reset: contents survive a reset.
  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_write_q, op_write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] readdata_q, readdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic             invalid_s;
  logic [IDX_W-1:0] idx_s;
  logic [31:0]      mem_rd_s;
  logic             mem_we_s;

  // An access is invalid when it is not word aligned or lies beyond the array.
  assign invalid_s = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));
  assign idx_s     = addr_q[IDX_W+1:2];

  // Array read of the latched word; forced to zero for an invalid access.
  always_comb begin
    mem_rd_s = 32'h0000_0000;
    if (!invalid_s) begin
      mem_rd_s = mem[idx_s];
    end else begin
      mem_rd_s = 32'h0000_0000;
    end
  end

  // Next-state and output logic: accept, count wait states, respond.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    readdata_d = readdata_q;
    ready_d    = ready_q;
    err_d      = err_q;
    mem_we_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.memread || bus.memwrite) begin
          // A write wins when both strobes are present.
          op_write_d = bus.memwrite;
          addr_d     = bus.addr;
          wdata_d    = bus.writedata;
          cnt_d      = WAIT_INIT;
          state_d    = ST_WAIT;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          err_d   = invalid_s;
          state_d = ST_RESP;
          if (op_write_q) begin
            mem_we_s = !invalid_s;
          end else begin
            readdata_d = mem_rd_s;
          end
        end
      end
      ST_RESP: begin
        ready_d = 1'b0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      op_write_q <= 1'b0;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      readdata_q <= 32'h0000_0000;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      readdata_q <= readdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  // Array write at completion of a valid store; gated by state, so a reset
  // during the wait leaves the array untouched.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[idx_s] <= wdata_q;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Self-checking bench: directed scenarios plus randomized accesses against
// a word-array reference model, on a WAIT_CYCLES=2 and a WAIT_CYCLES=0 DUT.
module tb_dmem_wait_responder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_wait_responder_if bus2();
  dmem_wait_responder_if bus0();

  dmem_wait_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  dmem_wait_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_m [64];
  logic [31:0] exp_rd2;

  // Single comparison point: counts and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One complete access on the WAIT_CYCLES=2 DUT, checked against the model.
  task automatic acc2(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input bit perturb);
    logic bad;
    int   lat;
    bit   seen;
    bad = (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
    @(negedge clk);
    bus2.memread   = rd;
    bus2.memwrite  = wr;
    bus2.addr      = a;
    bus2.writedata = d;
    @(posedge clk); #1;
    check_eq("accept_busy",  {31'b0, bus2.busy},  32'd1);
    check_eq("accept_ready", {31'b0, bus2.ready}, 32'd0);
    if (perturb) begin
      bus2.addr      = $urandom;
      bus2.writedata = $urandom;
      bus2.memread   = 1'($urandom_range(0, 1));
    end
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      lat = k;
      if (bus2.ready) begin
        seen = 1'b1;
      end else begin
        check_eq("wait_busy", {31'b0, bus2.busy}, 32'd1);
        if (perturb) bus2.writedata = $urandom;
      end
    end
    if (!seen) begin
      check_eq("ready_timeout", {31'b0, seen}, 32'd1);
      bus2.memread  = 1'b0;
      bus2.memwrite = 1'b0;
      return;
    end
    if (wr) begin
      if (!bad) mem_m[a[7:2]] = d;
    end else begin
      exp_rd2 = bad ? 32'h0 : mem_m[a[7:2]];
    end
    check_eq("latency",   32'(lat), 32'd3);
    check_eq("resp_busy", {31'b0, bus2.busy}, 32'd1);
    check_eq("err",       {31'b0, bus2.err},  {31'b0, bad});
    check_eq("readdata",  bus2.readdata, exp_rd2);
    bus2.memread  = 1'b0;
    bus2.memwrite = 1'b0;
    @(posedge clk); #1;
    check_eq("post_ready", {31'b0, bus2.ready}, 32'd0);
    check_eq("post_err",   {31'b0, bus2.err},   32'd0);
    check_eq("post_busy",  {31'b0, bus2.busy},  32'd0);
    check_eq("post_rdata", bus2.readdata, exp_rd2);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    int          op;

    reset = 1'b1;
    bus2.memread = 1'b0; bus2.memwrite = 1'b0; bus2.addr = 32'h0; bus2.writedata = 32'h0;
    bus0.memread = 1'b0; bus0.memwrite = 1'b0; bus0.addr = 32'h0; bus0.writedata = 32'h0;
    exp_rd2 = 32'h0;
    #1;
    check_eq("rst_ready",  {31'b0, bus2.ready}, 32'd0);
    check_eq("rst_busy",   {31'b0, bus2.busy},  32'd0);
    check_eq("rst_err",    {31'b0, bus2.err},   32'd0);
    check_eq("rst_rdata",  bus2.readdata,       32'h0);
    check_eq("rst0_busy",  {31'b0, bus0.busy},  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Give every word a known value.
    for (int i = 0; i < 64; i++) begin
      acc2(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);
    end

    // Write then read back.
    acc2(1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0);
    acc2(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    check_eq("deadbeef", bus2.readdata, 32'hDEAD_BEEF);
    // Misaligned write, neighbour unchanged; out-of-range read.
    acc2(1'b0, 1'b1, 32'h6, 32'h1234, 1'b0);
    acc2(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    acc2(1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
    // Simultaneous strobes act as a write; inputs wiggled during the wait.
    acc2(1'b1, 1'b1, 32'hC, 32'hA5A5_A5A5, 1'b1);
    acc2(1'b1, 1'b0, 32'hC, 32'h0, 1'b1);
    check_eq("a5_readback", bus2.readdata, 32'hA5A5_A5A5);
    // readdata holds across a later write.
    acc2(1'b0, 1'b1, 32'h30, 32'h55AA_55AA, 1'b0);
    acc2(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
    acc2(1'b0, 1'b1, 32'h34, 32'h0000_0777, 1'b0);
    check_eq("rdata_hold", bus2.readdata, 32'h55AA_55AA);

    // Reset during the wait aborts the write.
    acc2(1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
    @(negedge clk);
    bus2.memwrite = 1'b1; bus2.addr = 32'h10; bus2.writedata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("midrst_ready", {31'b0, bus2.ready}, 32'd0);
    check_eq("midrst_busy",  {31'b0, bus2.busy},  32'd0);
    check_eq("midrst_err",   {31'b0, bus2.err},   32'd0);
    check_eq("midrst_rdata", bus2.readdata,       32'h0);
    bus2.memwrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_rd2 = 32'h0;
    acc2(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

    // Randomized accesses.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else             a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      op = $urandom_range(0, 2);
      acc2(op != 1, op != 0, a, $urandom, 1'($urandom_range(0, 1)));
    end

    // WAIT_CYCLES=0: a held write request completes every third cycle.
    @(negedge clk);
    bus0.memwrite = 1'b1; bus0.addr = 32'h20; bus0.writedata = 32'h1111_2222;
    for (int i = 0; i <= 8; i++) begin
      @(posedge clk); #1;
      check_eq("w0_ready", {31'b0, bus0.ready}, {31'b0, (i == 1 || i == 4 || i == 7)});
      check_eq("w0_busy",  {31'b0, bus0.busy},  {31'b0, (i % 3 != 2)});
      check_eq("w0_err",   {31'b0, bus0.err},   32'd0);
    end
    bus0.memwrite = 1'b0; bus0.memread = 1'b1;
    for (int i = 0; i <= 2; i++) begin
      @(posedge clk); #1;
      check_eq("w0_rd_ready", {31'b0, bus0.ready}, {31'b0, (i == 1)});
      if (i >= 1) check_eq("w0_rdata", bus0.readdata, 32'h1111_2222);
    end
    bus0.memread = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
